btn_bit_encoder: RTL and testbench

- Front-end stage for the button-driven sequence detectors.
- Converts a raw, bouncing push-button into a clean stream of serial bits: short press = 0, long press = 1.
- Each bit is emitted as a one-cycle strobe (o_bit_valid) with o_bit, so the downstream detector advances exactly one state per press instead of sampling the button every clock.

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/btn_bit_encoder.sv | 128 ++++++++++++
 tb/tb_btn_bit_encoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and 100 MHz timing defaults for the button front-end blocks.
package btn_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } btn_state_t;

   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;    // 10 ms
   localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;   // 500 ms
   localparam int unsigned DEF_GAP_CYCLES      = 150_000_000;  // 1.5 s

   // Bits needed for a counter that must reach max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

   localparam int unsigned DEF_CNT_W = cnt_width(DEF_GAP_CYCLES);

endpackage

// File: rtl/btn_debounce.sv
// Input synchronizer plus stability-counter debouncer for a raw button.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_clean
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("btn_debounce: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   btn_sync;
   logic [CNT_W-1:0]       db_cnt;

   assign btn_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn};
      end
   end

   // Any return to the clean level restarts the stability window.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         db_cnt  <= '0;
         o_clean <= 1'b0;
      end else if (btn_sync == o_clean) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         o_clean <= btn_sync;
         db_cnt  <= '0;
      end else begin
         db_cnt <= db_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/btn_bit_encoder.sv
// Encodes debounced presses as serial bits (short = 0, long = 1) with a one-cycle strobe.
// Optional end-of-word strobe o_gap is built only when BTN_BIT_ENCODER_GAP_EN is defined.
module btn_bit_encoder
   import btn_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_btn_clean,
   output logic o_bit,
   output logic o_bit_valid,
   output logic o_long_hint,
   output logic o_gap
);

   localparam int unsigned MAX_DL  = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_DL > GAP_CYCLES) ? MAX_DL : GAP_CYCLES;
   localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_CYCLES);

   if (cnt_width(MAX_CYC) > CNT_W) begin : g_bad_cnt_w
      $error("btn_bit_encoder: CNT_W too small for the configured cycle counts");
   end

   logic             clean_q;
   logic             rise;
   logic             fall;
   logic             emit_pend;
   logic [CNT_W-1:0] dur_cnt;
   btn_state_t       state_q;
   btn_state_t       state_d;

   btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_btn   (i_btn),
      .o_clean (o_btn_clean)
   );

   assign rise = o_btn_clean & ~clean_q;
   assign fall = ~o_btn_clean & clean_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      o_long_hint = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) state_d = ST_HELD;
         end
         ST_HELD: begin
            o_long_hint = (dur_cnt == LONG_CNT);
            if (fall) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The fall cycle still counts toward the duration; the bit is sampled one
   // cycle later, so a clean-high run of LONG_CYCLES cycles encodes 1.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         clean_q     <= 1'b0;
         dur_cnt     <= '0;
         emit_pend   <= 1'b0;
         o_bit       <= 1'b0;
         o_bit_valid <= 1'b0;
      end else begin
         clean_q     <= o_btn_clean;
         o_bit_valid <= emit_pend;
         emit_pend   <= (state_q == ST_HELD) && fall;
         if (emit_pend) o_bit <= (dur_cnt >= LONG_CNT);
         if ((state_q == ST_IDLE) && rise) begin
            dur_cnt <= '0;
         end else if ((state_q == ST_HELD) && (dur_cnt != LONG_CNT)) begin
            dur_cnt <= dur_cnt + CNT_W'(1);
         end
      end
   end

`ifdef BTN_BIT_ENCODER_GAP_EN
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

   logic [CNT_W-1:0] gap_cnt;
   logic             gap_armed;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         gap_cnt   <= '0;
         gap_armed <= 1'b0;
      end else if (o_bit_valid) begin
         gap_cnt   <= '0;
         gap_armed <= 1'b1;
      end else if (rise) begin
         gap_cnt <= '0;
      end else if ((state_q == ST_IDLE) && gap_armed) begin
         if (gap_cnt == GAP_LAST) begin
            gap_cnt   <= '0;
            gap_armed <= 1'b0;
         end else begin
            gap_cnt <= gap_cnt + CNT_W'(1);
         end
      end
   end

   assign o_gap = gap_armed && (state_q == ST_IDLE) && !o_bit_valid && !rise
                  && (gap_cnt == GAP_LAST);
`else
   assign o_gap = 1'b0;
`endif

endmodule

// File: tb/tb_btn_bit_encoder.sv
// Directed self-checking bench for btn_bit_encoder (SYNC=2, DEBOUNCE=4, LONG=10, GAP=20).
module tb_btn_bit_encoder;

   logic i_clock;
   logic i_reset;
   logic i_btn;
   logic o_btn_clean;
   logic o_bit;
   logic o_bit_valid;
   logic o_long_hint;
   logic o_gap;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   int unsigned cyc = 0;
   logic        bit_q[$];
   int unsigned vcyc_q[$];
   int unsigned gap_q[$];
   int unsigned gap_total  = 0;
   int unsigned hint_cnt   = 0;
   int unsigned hint_first = 0;
   logic        clean_seen = 1'b0;

   btn_bit_encoder #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (10),
      .GAP_CYCLES      (20),
      .CNT_W           (8)
   ) dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_btn       (i_btn),
      .o_btn_clean (o_btn_clean),
      .o_bit       (o_bit),
      .o_bit_valid (o_bit_valid),
      .o_long_hint (o_long_hint),
      .o_gap       (o_gap)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   always @(posedge i_clock) cyc <= cyc + 1;

   always @(negedge i_clock) begin
      if (o_bit_valid === 1'b1) begin
         bit_q.push_back(o_bit);
         vcyc_q.push_back(cyc);
      end
      if (o_gap === 1'b1) begin
         gap_q.push_back(cyc);
         gap_total++;
      end
      if (o_long_hint === 1'b1) begin
         if (hint_cnt == 0) hint_first = cyc;
         hint_cnt++;
      end
      if (o_btn_clean === 1'b1) clean_seen = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge i_clock);
      #1;
   endtask

   task automatic clr();
      bit_q.delete();
      vcyc_q.delete();
      gap_q.delete();
      hint_cnt   = 0;
      hint_first = 0;
      clean_seen = 1'b0;
   endtask

   task automatic press(input int hold, output int unsigned rel);
      i_btn = 1'b1;
      tick(hold);
      i_btn = 1'b0;
      rel   = cyc;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   initial begin
      int unsigned rel;
      int unsigned p;
      int unsigned r[4];
      logic        seq_exp[4];

      i_reset = 1'b1;
      i_btn   = 1'b0;
      tick(3);
      check("rst_clean", o_btn_clean, 0);
      check("rst_bit", o_bit, 0);
      check("rst_valid", o_bit_valid, 0);
      check("rst_hint", o_long_hint, 0);
      check("rst_gap", o_gap, 0);
      i_reset = 1'b0;
      tick(5);

      // Bounce: 1,1,0,0 pattern for 12 cycles never survives the debouncer
      clr();
      for (int i = 0; i < 12; i++) begin
         i_btn = ((i / 2) % 2) == 0;
         tick(1);
      end
      i_btn = 1'b0;
      tick(15);
      check("bounce_clean", clean_seen, 0);
      check("bounce_strobes", bit_q.size(), 0);

      // Short press
      clr();
      press(8, rel);
      tick(12);
      check("short_count", bit_q.size(), 1);
      check("short_bit", bit_q[0], 0);
      check("short_latency", vcyc_q[0] - rel, 8);
      check("short_hint", hint_cnt, 0);

      // Boundary: 9 cycles -> 0, 10 cycles -> 1
      clr();
      press(9, rel);
      tick(12);
      check("b9_count", bit_q.size(), 1);
      check("b9_bit", bit_q[0], 0);
      clr();
      press(10, rel);
      tick(12);
      check("b10_count", bit_q.size(), 1);
      check("b10_bit", bit_q[0], 1);
      check("b10_hint", hint_cnt, 0);

      // 40-cycle hold: saturating counter, hint from clean rise + 11 to clean fall
      clr();
      p = cyc;
      press(40, rel);
      tick(12);
      check("long_count", bit_q.size(), 1);
      check("long_bit", bit_q[0], 1);
      check("long_latency", vcyc_q[0] - rel, 8);
      check("long_hint_cycles", hint_cnt, 30);
      check("long_hint_start", hint_first - p, 17);
      check("long_hint_off_at_strobe", o_long_hint, 0);

      // Sequence 0,1,0,1 with 6-cycle gaps
      clr();
      seq_exp[0] = 1'b0; seq_exp[1] = 1'b1; seq_exp[2] = 1'b0; seq_exp[3] = 1'b1;
      press(6, r[0]);  tick(6);
      press(12, r[1]); tick(6);
      press(6, r[2]);  tick(6);
      press(12, r[3]); tick(12);
      check("seq_count", bit_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("seq_bit%0d", i), bit_q[i], seq_exp[i]);
         check($sformatf("seq_latency%0d", i), vcyc_q[i] - r[i], 8);
      end
      check("seq_bit_holds", o_bit, 1);

      // Reset five cycles into a clean hold; press re-measured from post-reset rise
      clr();
      i_btn = 1'b1;
      p = cyc;
      tick(11);
      check("mid_clean_before", o_btn_clean, 1);
      i_reset = 1'b1;
      tick(1);
      check("mid_rst_clean", o_btn_clean, 0);
      check("mid_rst_bit", o_bit, 0);
      check("mid_rst_valid", o_bit_valid, 0);
      check("mid_rst_hint", o_long_hint, 0);
      check("mid_rst_gap", o_gap, 0);
      i_reset = 1'b0;
      tick(9);
      i_btn = 1'b0;
      rel   = cyc;
      tick(14);
      check("mid_count", bit_q.size(), 1);
      check("mid_bit", bit_q[0], 0);
      check("mid_latency", vcyc_q[0] - rel, 8);

`ifdef BTN_BIT_ENCODER_GAP_EN
      clr();
      press(6, rel);
      tick(80);
      check("gap_strobe_count", bit_q.size(), 1);
      check("gap_pulses", gap_q.size(), 1);
      check("gap_delay", gap_q[0] - vcyc_q[0], 20);
`else
      tick(40);
      check("gap_never", gap_total, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
